rc4_prga_decrypt: RTL and testbench
===================================

// Module: rc4_prga_decrypt
// PURPOSE
//  RC4 PRGA/decrypt stage; sits directly downstream of the key-schedule stage in the key-search datapath.
//  On start, with S already key-scheduled: generates MSG_LEN keystream bytes, XORs each with the encrypted-message ROM,
//  and writes the plaintext to the decrypted-message RAM.
//  Reports done and valid; valid means every byte is 'a'..'z' or space. The key-search FSM uses valid to accept or reject a key.
// PARAMETERS
//  MSG_LEN   32  message length in bytes (number of PRGA iterations)
//  MSG_AW    5   ROM / decrypt RAM address width; MSG_LEN <= 2**MSG_AW
// PORTS
//  clock            in   1       single clock; all state changes on rising edge
//  reset            in   1       synchronous, active-high
//  start            in   1       level; sampled in IDLE or DONE to begin a pass
//  done             out  1       high while in DONE
//  valid            out  1       qualified by done; 1 = plaintext passed the character check
//  s_address        out  8       S RAM address
//  s_data           out  8       S RAM write data
//  s_wren           out  1       S RAM write enable
//  s_q              in   8       S RAM read data
//  rom_address      out  MSG_AW  encrypted ROM address
//  rom_q            in   8       encrypted ROM data
//  decrypt_address  out  MSG_AW  plaintext RAM address
//  decrypt_data     out  8       plaintext RAM write data
//  decrypt_wren     out  1       plaintext RAM write enable
// BEHAVIOUR
//  - Memories: synchronous read. Address driven in state X; q sampled in state X+2 (one WAIT state between).
//  - Reset, including mid-pass: state=IDLE. i=j=k=0. done=valid=0, all wren=0, all addresses/data=0.
//    S/decrypt contents are left as partially written; the caller re-runs the key schedule.
//  - Per byte k: i=i+1 (mod 256), j=j+S[i] (mod 256), swap S[i]/S[j], f=S[(S[i]+S[j]) mod 256], out[k]=f^rom[k].
//    All index arithmetic is 8-bit wrap-around, no carry.
//  - FSM, 9 cycles per byte:
//      IDLE     -> RD_SI when start; otherwise stay
//      RD_SI    (addr i+1, latch i) -> WAIT_SI -> RD_SJ
//      RD_SJ    (si=s_q; j=j+si; addr j) -> WAIT_SJ -> WR_SI
//      WR_SI    (sj=s_q; write S[i]=sj) -> WR_SJ
//      WR_SJ    (write S[j]=si) -> RD_F
//      RD_F     (addr si+sj; rom_address=k) -> WAIT_F -> WR_OUT
//      WR_OUT   (write decrypt[k]=s_q^rom_q; update valid) -> RD_SI if k<MSG_LEN-1 (k++), else DONE
//      DONE     holds done=1 and valid; start -> RD_SI with i=j=k=0, done=0, valid=1
//  - Swap with i==j: both writes go to the same address and S is unchanged. This is the required result, not an error.
//  - Writes are one-cycle wren pulses. S writes never overlap decrypt writes.
//  - start while busy is ignored. From IDLE, done=1 exactly 9*MSG_LEN+1 edges after start is sampled.
//  - valid is set to 1 at pass start and cleared by the first failing byte. It is meaningful only when done=1.
// CONFIGURATION
//  RC4_EARLY_ABORT_EN defined:
//    the first failing byte in WR_OUT is still written, then the FSM goes straight to DONE with valid=0.
//  RC4_EARLY_ABORT_EN undefined:
//    always processes all MSG_LEN bytes; valid is the AND of all per-byte checks.
// STRUCTURE
//  rc4_pkg: state enum, CHAR_SPACE=8'h20, CHAR_A=8'h61, CHAR_Z=8'h7A. Shared with the key-schedule and search FSMs.
//  Sub-module rc4_char_check: combinational, in byte -> out ok. Reused by the search FSM.
// TESTING
//  1. S identity (S[n]=n), rom[0]=8'h63, rom[1]=8'h67, remaining rom[k]=keystream^8'h61.
//     -> decrypt[0..1]=8'h61,8'h62; all others 8'h61; valid=1; done after 9*32+1 clocks.
//  2. S identity, rom all 8'h00 -> decrypt[0]=8'h02, valid=0.
//     With EN: done after 10 clocks, decrypt[1] not written.
//     Without EN: done after 289 clocks, decrypt[1]=8'h05.
//  3. Byte 0 has i==j==1 (identity S) -> S[1] stays 8'h01 after the pass start. Check the S RAM write trace shows 2 writes of 8'h01 to addr 1.
//  4. Assert reset in WR_SI of byte 5 -> next cycle IDLE, done=0, all wren=0. A new start completes a clean pass.
//  5. Pulse start during a pass -> no effect, same cycle count. In DONE with start held high -> second pass starts, done drops.
//  6. Known RC4 vector: key 24'h000000 schedule (reference model) with ROM from that key -> matches model byte-for-byte, valid=1.

Source files
------------

// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared RC4 PRGA state encoding and plaintext character constants
//
// Purpose: common definitions for the RC4 key-search datapath. The PRGA state
// enum and the character bounds are shared by the key-schedule, PRGA/decrypt
// and search FSMs.
// Ports: none (package).

package rc4_pkg;

    // Plaintext alphabet accepted by the key search: lowercase letters and space.
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_A     = 8'h61;
    localparam logic [7:0] CHAR_Z     = 8'h7A;

    // PRGA/decrypt states. Each byte walks RD_SI..WR_OUT, 9 states in total;
    // the WAIT states cover the one-cycle read latency of the RAM/ROM.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RD_SI   = 4'd1,
        ST_WAIT_SI = 4'd2,
        ST_RD_SJ   = 4'd3,
        ST_WAIT_SJ = 4'd4,
        ST_WR_SI   = 4'd5,
        ST_WR_SJ   = 4'd6,
        ST_RD_F    = 4'd7,
        ST_WAIT_F  = 4'd8,
        ST_WR_OUT  = 4'd9,
        ST_DONE    = 4'd10
    } rc4_prga_state_t;

endpackage

// File: rtl/rc4_prga_decrypt_if.sv
// rtl/rc4_prga_decrypt_if.sv - control and memory bus of the RC4 PRGA/decrypt stage
//
// Purpose: bundles the start/done/valid handshake with the S RAM, encrypted
// ROM and decrypted-message RAM buses. Signal prefixes are from the point of
// view of the PRGA stage (master): i_ = into the stage, o_ = out of it.
// Signals:
//   i_start            level start request
//   o_done, o_valid    pass complete / plaintext passed the character check
//   o_s_address, o_s_data, o_s_wren, i_s_q                 S RAM
//   o_rom_address, i_rom_q                                 encrypted ROM
//   o_decrypt_address, o_decrypt_data, o_decrypt_wren      plaintext RAM
// Modports: master (PRGA stage), slave (memories and key-search FSM side).

interface rc4_prga_decrypt_if #(
    parameter int MSG_AW = 5
) ();
    logic              i_start;
    logic              o_done;
    logic              o_valid;
    logic [7:0]        o_s_address;
    logic [7:0]        o_s_data;
    logic              o_s_wren;
    logic [7:0]        i_s_q;
    logic [MSG_AW-1:0] o_rom_address;
    logic [7:0]        i_rom_q;
    logic [MSG_AW-1:0] o_decrypt_address;
    logic [7:0]        o_decrypt_data;
    logic              o_decrypt_wren;

    modport master (
        input  i_start, i_s_q, i_rom_q,
        output o_done, o_valid,
        output o_s_address, o_s_data, o_s_wren,
        output o_rom_address,
        output o_decrypt_address, o_decrypt_data, o_decrypt_wren
    );

    modport slave (
        output i_start, i_s_q, i_rom_q,
        input  o_done, o_valid,
        input  o_s_address, o_s_data, o_s_wren,
        input  o_rom_address,
        input  o_decrypt_address, o_decrypt_data, o_decrypt_wren
    );
endinterface

// File: rtl/rc4_char_check.sv
// rtl/rc4_char_check.sv - combinational plaintext character check
//
// Purpose: flags whether a decrypted byte belongs to the accepted plaintext
// alphabet ('a'..'z' or space). Also used by the key-search FSM.
// Ports:
//   i_byte  in   8  candidate plaintext byte
//   o_ok    out  1  1 when i_byte is a lowercase letter or a space

module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_ok
);

    logic w_is_space;
    logic w_is_lower;

    assign w_is_space = (i_byte == CHAR_SPACE);
    assign w_is_lower = (i_byte >= CHAR_A) && (i_byte <= CHAR_Z);
    assign o_ok       = w_is_space | w_is_lower;

endmodule

// File: rtl/rc4_prga_decrypt.sv
// rtl/rc4_prga_decrypt.sv - RC4 PRGA keystream generation and message decrypt
//
// Purpose: with S already key-scheduled, generates MSG_LEN keystream bytes,
// XORs each with the encrypted ROM and writes the plaintext into the decrypt
// RAM. Reports done plus a valid flag (every byte 'a'..'z' or space).
// Optional feature macro: RC4_EARLY_ABORT_EN - stop at the first failing byte
// (that byte is still written) and go to DONE with valid=0.
// Parameters:
//   MSG_LEN  message length in bytes
//   MSG_AW   ROM / decrypt RAM address width, MSG_LEN <= 2**MSG_AW
// Ports:
//   i_clock  in  1  rising-edge clock
//   i_reset  in  1  synchronous active-high reset
//   bus      rc4_prga_decrypt_if.master: start/done/valid and the S RAM,
//            encrypted ROM and decrypt RAM buses (all memories read with a
//            one-cycle synchronous latency)

module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic               i_clock,
    input  logic               i_reset,
    rc4_prga_decrypt_if.master bus
);

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    rc4_prga_state_t   r_state;
    rc4_prga_state_t   w_state_next;

    logic [7:0]        r_i;
    logic [7:0]        r_j;
    logic [MSG_AW-1:0] r_k;
    logic [7:0]        r_si;
    logic [7:0]        r_sj;
    logic              r_valid;

    logic [7:0]        w_i_next;
    logic [7:0]        w_j_next;
    logic [MSG_AW-1:0] w_k_next;
    logic [7:0]        w_si_next;
    logic [7:0]        w_sj_next;
    logic              w_valid_next;

    logic [7:0]        w_j_sum;
    logic [7:0]        w_f_addr;
    logic [7:0]        w_plain;
    logic              w_char_ok;

    // 8-bit wrap-around is the RC4 index rule, so plain 8-bit adders suffice.
    assign w_j_sum  = r_j + bus.i_s_q;
    assign w_f_addr = r_si + r_sj;
    assign w_plain  = bus.i_s_q ^ bus.i_rom_q;

    rc4_char_check u_char_check (
        .i_byte (w_plain),
        .o_ok   (w_char_ok)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_si    <= '0;
            r_sj    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_i     <= w_i_next;
            r_j     <= w_j_next;
            r_k     <= w_k_next;
            r_si    <= w_si_next;
            r_sj    <= w_sj_next;
            r_valid <= w_valid_next;
        end
    end

    always_comb begin
        w_state_next          = r_state;
        w_i_next              = r_i;
        w_j_next              = r_j;
        w_k_next              = r_k;
        w_si_next             = r_si;
        w_sj_next             = r_sj;
        w_valid_next          = r_valid;

        bus.o_done            = 1'b0;
        bus.o_valid           = 1'b0;
        bus.o_s_address       = '0;
        bus.o_s_data          = '0;
        bus.o_s_wren          = 1'b0;
        bus.o_rom_address     = '0;
        bus.o_decrypt_address = '0;
        bus.o_decrypt_data    = '0;
        bus.o_decrypt_wren    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_state_next = ST_RD_SI;
                    w_i_next     = '0;
                    w_j_next     = '0;
                    w_k_next     = '0;
                    w_valid_next = 1'b1;
                end
            end

            // r_i is bumped on leaving RD_SI, so WAIT_SI holds the same
            // address through r_i itself.
            ST_RD_SI: begin
                bus.o_s_address = r_i + 8'd1;
                w_i_next        = r_i + 8'd1;
                w_state_next    = ST_WAIT_SI;
            end

            ST_WAIT_SI: begin
                bus.o_s_address = r_i;
                w_state_next    = ST_RD_SJ;
            end

            // S[i] arrives now; the new j is used as the read address in the
            // same cycle, then held from r_j during WAIT_SJ.
            ST_RD_SJ: begin
                w_si_next       = bus.i_s_q;
                w_j_next        = w_j_sum;
                bus.o_s_address = w_j_sum;
                w_state_next    = ST_WAIT_SJ;
            end

            ST_WAIT_SJ: begin
                bus.o_s_address = r_j;
                w_state_next    = ST_WR_SI;
            end

            // When i == j both halves of the swap hit the same address with
            // the same value, leaving S unchanged as RC4 requires.
            ST_WR_SI: begin
                w_sj_next       = bus.i_s_q;
                bus.o_s_address = r_i;
                bus.o_s_data    = bus.i_s_q;
                bus.o_s_wren    = 1'b1;
                w_state_next    = ST_WR_SJ;
            end

            ST_WR_SJ: begin
                bus.o_s_address = r_j;
                bus.o_s_data    = r_si;
                bus.o_s_wren    = 1'b1;
                w_state_next    = ST_RD_F;
            end

            // The pre-swap values are used for the f index; after the swap
            // S[i]+S[j] is the same sum.
            ST_RD_F: begin
                bus.o_s_address   = w_f_addr;
                bus.o_rom_address = r_k;
                w_state_next      = ST_WAIT_F;
            end

            ST_WAIT_F: begin
                bus.o_s_address   = w_f_addr;
                bus.o_rom_address = r_k;
                w_state_next      = ST_WR_OUT;
            end

            ST_WR_OUT: begin
                bus.o_s_address       = w_f_addr;
                bus.o_rom_address     = r_k;
                bus.o_decrypt_address = r_k;
                bus.o_decrypt_data    = w_plain;
                bus.o_decrypt_wren    = 1'b1;
                w_valid_next          = r_valid & w_char_ok;
`ifdef RC4_EARLY_ABORT_EN
                if (!w_char_ok || (r_k == K_LAST)) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_k_next     = r_k + MSG_AW'(1);
                    w_state_next = ST_RD_SI;
                end
`else
                if (r_k == K_LAST) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_k_next     = r_k + MSG_AW'(1);
                    w_state_next = ST_RD_SI;
                end
`endif
            end

            ST_DONE: begin
                bus.o_done  = 1'b1;
                bus.o_valid = r_valid;
                if (bus.i_start) begin
                    w_state_next = ST_RD_SI;
                    w_i_next     = '0;
                    w_j_next     = '0;
                    w_k_next     = '0;
                    w_valid_next = 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// tb/tb_rc4_prga_decrypt.sv - self-checking bench for rc4_prga_decrypt

module tb_rc4_prga_decrypt;

    localparam int MSG_LEN = 32;
    localparam int MSG_AW  = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rc4_prga_decrypt_if #(.MSG_AW(MSG_AW)) bus ();

    rc4_prga_decrypt #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Memory models (synchronous read, one-cycle latency) plus write monitors.
    logic [7:0] s_mem  [256];
    logic [7:0] s_init [256];
    logic [7:0] rom    [MSG_LEN];
    logic [7:0] dec    [MSG_LEN];
    logic       mem_init = 1'b0;
    int         dec_writes;
    int         s_writes;
    int         tr_addr [$];
    int         tr_data [$];

    always @(posedge clk) begin
        bus.i_s_q   <= s_mem[bus.o_s_address];
        bus.i_rom_q <= rom[bus.o_rom_address];
        if (mem_init) begin
            for (int n = 0; n < 256; n++) s_mem[n] <= s_init[n];
            for (int n = 0; n < MSG_LEN; n++) dec[n] <= 8'h00;
            dec_writes = 0;
            s_writes   = 0;
            tr_addr.delete();
            tr_data.delete();
        end else begin
            if (bus.o_s_wren === 1'b1) begin
                s_mem[bus.o_s_address] <= bus.o_s_data;
                s_writes = s_writes + 1;
                tr_addr.push_back(int'(bus.o_s_address));
                tr_data.push_back(int'(bus.o_s_data));
            end
            if (bus.o_decrypt_wren === 1'b1) begin
                dec[bus.o_decrypt_address] <= bus.o_decrypt_data;
                dec_writes = dec_writes + 1;
            end
        end
    end

    // Reference model: plain RC4 PRGA on arrays.
    logic [7:0] m_s   [256];
    logic [7:0] m_out [MSG_LEN];
    logic [7:0] ks    [MSG_LEN];
    logic [7:0] plain [MSG_LEN];
    logic       m_valid;
    int         m_nbytes;

    function automatic logic char_ok(input logic [7:0] b);
        return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7a);
    endfunction

    task automatic ks_preview();
        logic [7:0] s [256];
        logic [7:0] t;
        int i = 0;
        int j = 0;
        for (int n = 0; n < 256; n++) s[n] = m_s[n];
        for (int k = 0; k < MSG_LEN; k++) begin
            i = (i + 1) % 256;
            j = (j + int'(s[i])) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            ks[k] = s[(int'(s[i]) + int'(s[j])) % 256];
        end
    endtask

    task automatic model_pass();
        logic [7:0] t;
        int i = 0;
        int j = 0;
        m_valid  = 1'b1;
        m_nbytes = 0;
        for (int k = 0; k < MSG_LEN; k++) begin
            i = (i + 1) % 256;
            j = (j + int'(m_s[i])) % 256;
            t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
            m_out[k] = m_s[(int'(m_s[i]) + int'(m_s[j])) % 256] ^ rom[k];
            m_nbytes++;
            if (!char_ok(m_out[k])) begin
                m_valid = 1'b0;
`ifdef RC4_EARLY_ABORT_EN
                break;
`endif
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_identity();
        for (int n = 0; n < 256; n++) m_s[n] = 8'(n);
    endtask

    task automatic load_mems();
        for (int n = 0; n < 256; n++) s_init[n] = m_s[n];
        mem_init = 1'b1;
        @(posedge clk); #1;
        mem_init = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 1;
        while (bus.o_done !== 1'b1 && cycles < 2000) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic run_pass(input int pulse_at, output int cycles);
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        cycles = 1;
        while (bus.o_done !== 1'b1 && cycles < 2000) begin
            bus.i_start = (cycles == pulse_at);
            @(posedge clk); #1;
            cycles++;
        end
        bus.i_start = 1'b0;
    endtask

    task automatic check_pass(input string tag, input int cycles);
        int bad_b;
        int bad_s;
        bad_b = 0;
        bad_s = 0;
        chk({tag, "_cycles"}, cycles, 9 * m_nbytes + 1);
        chk({tag, "_done"}, bus.o_done, 1);
        chk({tag, "_valid"}, bus.o_valid, m_valid);
        chk({tag, "_dec_writes"}, dec_writes, m_nbytes);
        for (int k = 0; k < m_nbytes; k++) if (dec[k] !== m_out[k]) bad_b++;
        chk({tag, "_bytes_bad"}, bad_b, 0);
        for (int n = 0; n < 256; n++) if (s_mem[n] !== m_s[n]) bad_s++;
        chk({tag, "_s_bad"}, bad_s, 0);
    endtask

    task automatic rand_plain();
        int r;
        for (int k = 0; k < MSG_LEN; k++) begin
            r = $urandom_range(0, 26);
            plain[k] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
        end
    endtask

    initial begin
        int cyc;
        int n;
        int r;
        logic [7:0] t;
        logic [7:0] key [3];
        int j;

        rst = 1'b1;
        bus.i_start = 1'b0;
        set_identity();
        for (int k = 0; k < MSG_LEN; k++) rom[k] = 8'h00;
        load_mems();
        @(posedge clk); #1;
        chk("reset_done", bus.o_done, 0);
        chk("reset_valid", bus.o_valid, 0);
        chk("reset_s_wren", bus.o_s_wren, 0);
        chk("reset_dec_wren", bus.o_decrypt_wren, 0);
        chk("reset_s_addr", bus.o_s_address, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1 + 3: identity S, plaintext "ab" followed by 'a's; swap trace.
        set_identity();
        load_mems();
        ks_preview();
        rom[0] = 8'h63;
        rom[1] = 8'h67;
        for (int k = 2; k < MSG_LEN; k++) rom[k] = ks[k] ^ 8'h61;
        model_pass();
        run_pass(-1, cyc);
        check_pass("t1", cyc);
        chk("t1_cycles_const", cyc, 289);
        chk("t1_dec0", dec[0], 8'h61);
        chk("t1_dec1", dec[1], 8'h62);
        chk("t1_dec31", dec[31], 8'h61);
        chk("t3_w0_addr", tr_addr[0], 1);
        chk("t3_w0_data", tr_data[0], 1);
        chk("t3_w1_addr", tr_addr[1], 1);
        chk("t3_w1_data", tr_data[1], 1);
        chk("t3_s1", s_mem[1], 8'h01);

        // 2: identity S, all-zero ROM -> first byte fails the check.
        set_identity();
        load_mems();
        for (int k = 0; k < MSG_LEN; k++) rom[k] = 8'h00;
        model_pass();
        run_pass(-1, cyc);
        check_pass("t2", cyc);
        chk("t2_dec0", dec[0], 8'h02);
        chk("t2_valid", bus.o_valid, 0);
`ifdef RC4_EARLY_ABORT_EN
        chk("t2_cycles_const", cyc, 10);
        chk("t2_dec_writes_const", dec_writes, 1);
`else
        chk("t2_cycles_const", cyc, 289);
        chk("t2_dec1", dec[1], 8'h05);
`endif

        // 4: reset asserted in WR_SI of byte 5, then a clean pass.
        set_identity();
        load_mems();
        ks_preview();
        for (int k = 0; k < MSG_LEN; k++) rom[k] = ks[k] ^ 8'h7a;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        n = 0;
        while (!(bus.o_s_wren === 1'b1 && s_writes == 10) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t4_reached_wr_si", (n < 500), 1);
        chk("t4_dec_writes_before", dec_writes, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t4_done", bus.o_done, 0);
        chk("t4_s_wren", bus.o_s_wren, 0);
        chk("t4_dec_wren", bus.o_decrypt_wren, 0);
        chk("t4_s_addr", bus.o_s_address, 0);
        chk("t4_rom_addr", bus.o_rom_address, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t4_idle_no_done", bus.o_done, 0);
        load_mems();
        model_pass();
        run_pass(-1, cyc);
        check_pass("t4", cyc);

        // 5: random permutation of S, start pulsed mid-pass, then held in DONE.
        set_identity();
        for (int m = 255; m > 0; m--) begin
            r = $urandom_range(0, m);
            t = m_s[m]; m_s[m] = m_s[r]; m_s[r] = t;
        end
        load_mems();
        ks_preview();
        rand_plain();
        for (int k = 0; k < MSG_LEN; k++) rom[k] = ks[k] ^ plain[k];
        model_pass();
        run_pass(100, cyc);
        check_pass("t5a", cyc);
        chk("t5a_valid_const", bus.o_valid, 1);
        model_pass();
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        chk("t5_restart_done_drops", bus.o_done, 0);
        bus.i_start = 1'b0;
        mem_init = 1'b0;
        dec_writes = 0;
        wait_done(cyc);
        chk("t5b_cycles", cyc, 9 * m_nbytes + 1);
        chk("t5b_valid", bus.o_valid, m_valid);
        n = 0;
        for (int k = 0; k < m_nbytes; k++) if (dec[k] !== m_out[k]) n++;
        chk("t5b_bytes_bad", n, 0);

        // 6: key 24'h000000 scheduled by the model, random lowercase plaintext.
        key[0] = 8'h00; key[1] = 8'h00; key[2] = 8'h00;
        set_identity();
        j = 0;
        for (int i = 0; i < 256; i++) begin
            j = (j + int'(m_s[i]) + int'(key[i % 3])) % 256;
            t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
        end
        load_mems();
        ks_preview();
        rand_plain();
        for (int k = 0; k < MSG_LEN; k++) rom[k] = ks[k] ^ plain[k];
        model_pass();
        run_pass(-1, cyc);
        check_pass("t6", cyc);
        chk("t6_valid_const", bus.o_valid, 1);
        n = 0;
        for (int k = 0; k < MSG_LEN; k++) if (dec[k] !== plain[k]) n++;
        chk("t6_plain_bad", n, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
